// File: rtl/l1_wb_pkg.sv
// Shared definitions for the L1 write buffer slice.
// Holds the default geometry (address width, data width, entry count) and
// the drain-state encoding used by the write-buffer drain FSM.
package l1_wb_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int DATA_W_DEFAULT = 16;
  localparam int DEPTH_DEFAULT  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drainStateT;

endpackage

// File: rtl/l1_wb_cam.sv
// Address match array for the L1 write buffer.
// Compares every entry address against the store address and the
// read-miss check address, and picks the youngest match of each.
//
// Ports
//   entryAddr / entryValid  entry addresses and valid bits
//   headPtr                 oldest entry index (age origin)
//   headInFlight            head is being drained; excluded from store match
//   wr_addr / chk_addr      store address / forwarding check address
//   wrMatch / chkMatch      per-entry match vectors
//   wrIdx / chkIdx          index of the youngest matching entry
module l1_wb_cam
  import l1_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] entryAddr,
  input  logic [DEPTH-1:0]             entryValid,
  input  logic [PTR_W-1:0]             headPtr,
  input  logic                         headInFlight,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [ADDR_W-1:0]            chk_addr,
  output logic [DEPTH-1:0]             wrMatch,
  output logic [DEPTH-1:0]             chkMatch,
  output logic [PTR_W-1:0]             wrIdx,
  output logic [PTR_W-1:0]             chkIdx
);

  always_comb begin
    wrMatch  = '0;
    chkMatch = '0;
    for (int i = 0; i < DEPTH; i++) begin
      chkMatch[i] = entryValid[i] && (entryAddr[i] == chk_addr);
      // the entry currently presented to L2 must not change under it
      wrMatch[i]  = entryValid[i] && (entryAddr[i] == wr_addr) &&
                    !(headInFlight && (PTR_W'(i) == headPtr));
    end
  end

  // Walk from oldest (head) to youngest; the last match seen wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    wrIdx  = '0;
    chkIdx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = headPtr + PTR_W'(k);
      if (wrMatch[idx]) wrIdx = idx;
      if (chkMatch[idx]) chkIdx = idx;
    end
  end

endmodule

// File: rtl/l1_write_buffer.sv
// L1 write-through store buffer with coalescing, read-miss forwarding and
// an in-order drain port to L2.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data       store request; wr_ready = accepted (comb)
//   chk_addr                    read-miss address; fwd_hit/fwd_data (comb)
//   l2_req/l2_addr/l2_data      registered drain request to L2
//   l2_ack                      L2 accepted current request
//   empty, count                occupancy
//
// Drain FSM
//   state | meaning
//   IDLE  | no request to L2 outstanding
//   REQ   | head entry presented on l2_*, waiting for l2_ack
module l1_write_buffer
  import l1_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          chk_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic                       l2_req,
  output logic [ADDR_W-1:0]          l2_addr,
  output logic [DATA_W-1:0]          l2_data,
  input  logic                       l2_ack,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] entryAddr, addrNext;
  logic [DEPTH-1:0][DATA_W-1:0] entryData, dataNext;
  logic [DEPTH-1:0]             entryValid, validNext;
  logic [PTR_W-1:0]             headPtr, tailPtr, loadPtr;
  logic [CNT_W-1:0]             countQ, countNext;
  drainStateT                   stateQ, stateD;

  logic [DEPTH-1:0] wrMatch, chkMatch;
  logic [PTR_W-1:0] wrIdx, chkIdx;
  logic             wrHit, isFull, doCoalesce, doPush, doPop, loadHead;

  l1_wb_cam #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) uCam (
    .entryAddr    (entryAddr),
    .entryValid   (entryValid),
    .headPtr      (headPtr),
    .headInFlight (stateQ == REQ),
    .wr_addr      (wr_addr),
    .chk_addr     (chk_addr),
    .wrMatch      (wrMatch),
    .chkMatch     (chkMatch),
    .wrIdx        (wrIdx),
    .chkIdx       (chkIdx)
  );

  assign wrHit  = |wrMatch;
  // registered count only: a pop in the same cycle does not free a slot
  assign isFull = (countQ == CNT_W'(DEPTH));

  assign doCoalesce = !reset && wr_en && wrHit;
  assign doPush     = !reset && wr_en && !wrHit && !isFull;
  assign doPop      = (stateQ == REQ) && l2_ack;
  assign wr_ready   = !reset && (wrHit || !isFull);

  assign countNext = countQ + CNT_W'(doPush) - CNT_W'(doPop);
  assign loadPtr   = doPop ? headPtr + PTR_W'(1) : headPtr;

  assign fwd_hit  = |chkMatch;
  assign fwd_data = fwd_hit ? entryData[chkIdx] : '0;
  assign empty    = (countQ == '0);
  assign count    = countQ;

  // Post-edge entry contents; the L2 load reads these so that a store
  // landing on the next head in the same cycle is not missed.
  always_comb begin
    addrNext  = entryAddr;
    dataNext  = entryData;
    validNext = entryValid;
    if (doPop) validNext[headPtr] = 1'b0;
    if (doCoalesce) dataNext[wrIdx] = wr_data;
    if (doPush) begin
      addrNext[tailPtr]  = wr_addr;
      dataNext[tailPtr]  = wr_data;
      validNext[tailPtr] = 1'b1;
    end
  end

  always_comb begin
    stateD   = stateQ;
    loadHead = 1'b0;
    case (stateQ)
      IDLE: begin
        if (countQ != '0) begin
          stateD   = REQ;
          loadHead = 1'b1;
        end
      end
      REQ: begin
        if (l2_ack) begin
          if (countNext != '0) loadHead = 1'b1;
          else stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) stateQ <= IDLE;
    else stateQ <= stateD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entryValid <= '0;
      headPtr    <= '0;
      tailPtr    <= '0;
      countQ     <= '0;
      l2_req     <= 1'b0;
      l2_addr    <= '0;
      l2_data    <= '0;
    end else begin
      entryValid <= validNext;
      entryAddr  <= addrNext;
      entryData  <= dataNext;
      countQ     <= countNext;
      if (doPop) headPtr <= headPtr + PTR_W'(1);
      if (doPush) tailPtr <= tailPtr + PTR_W'(1);
      l2_req <= (stateD == REQ);
      if (loadHead) begin
        l2_addr <= addrNext[loadPtr];
        l2_data <= dataNext[loadPtr];
      end
    end
  end

endmodule

// File: tb/tb_l1_write_buffer.sv
module tb_l1_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [15:0] chk_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        l2_req;
  logic [15:0] l2_addr;
  logic [15:0] l2_data;
  logic        l2_ack;
  logic        empty;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  l1_write_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .chk_addr (chk_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .l2_req   (l2_req),
    .l2_addr  (l2_addr),
    .l2_data  (l2_data),
    .l2_ack   (l2_ack),
    .empty    (empty),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setWr(input logic en, input logic [15:0] a, input logic [15:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    reset    = 1'b1;
    l2_ack   = 1'b0;
    chk_addr = 16'h0000;
    setWr(1'b1, 16'h0000, 16'd5);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 0);
    cyc();
    cyc();
    setWr(1'b0, 16'h0000, 16'd0);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_l2_req", 32'(l2_req), 0);
    check("rst_l2_addr", 32'(l2_addr), 0);
    check("rst_l2_data", 32'(l2_data), 0);
    check("rst_fwd_hit", 32'(fwd_hit), 0);
    reset = 1'b0;

    // single store, drain held off
    setWr(1'b1, 16'h0000, 16'd23);
    #1;
    check("w23_ready", 32'(wr_ready), 1);
    cyc();
    setWr(1'b0, 16'h0000, 16'd0);
    check("w23_count", 32'(count), 1);
    cyc();
    check("w23_req", 32'(l2_req), 1);
    check("w23_addr", 32'(l2_addr), 16'h0000);
    check("w23_data", 32'(l2_data), 23);
    cyc();
    cyc();
    check("w23_hold_req", 32'(l2_req), 1);
    check("w23_hold_data", 32'(l2_data), 23);
    check("w23_hold_count", 32'(count), 1);

    // store to in-flight head address appends
    setWr(1'b1, 16'h0000, 16'd31);
    #1;
    check("w31_ready", 32'(wr_ready), 1);
    cyc();
    setWr(1'b0, 16'h0000, 16'd0);
    chk_addr = 16'h0000;
    #1;
    check("w31_count", 32'(count), 2);
    check("w31_fwd_hit", 32'(fwd_hit), 1);
    check("w31_fwd_data", 32'(fwd_data), 31);
    check("w31_head_data", 32'(l2_data), 23);
    l2_ack = 1'b1;
    cyc();
    check("drain2_req", 32'(l2_req), 1);
    check("drain2_data", 32'(l2_data), 31);
    check("drain2_count", 32'(count), 1);
    cyc();
    check("drain_end_req", 32'(l2_req), 0);
    check("drain_end_empty", 32'(empty), 1);

    // ack while idle has no effect
    cyc();
    check("idle_ack_req", 32'(l2_req), 0);
    check("idle_ack_count", 32'(count), 0);
    l2_ack = 1'b0;

    // coalesce behind an in-flight head
    setWr(1'b1, 16'h0003, 16'd7);
    cyc();
    setWr(1'b0, 16'h0000, 16'd0);
    cyc();
    check("h7_addr", 32'(l2_addr), 16'h0003);
    check("h7_data", 32'(l2_data), 7);
    setWr(1'b1, 16'h0001, 16'd42);
    cyc();
    setWr(1'b1, 16'h0002, 16'd51);
    cyc();
    check("pre_coal_count", 32'(count), 3);
    setWr(1'b1, 16'h0001, 16'd99);
    chk_addr = 16'h0001;
    l2_ack   = 1'b1;
    #1;
    check("coal_ready", 32'(wr_ready), 1);
    check("coal_fwd_pre", 32'(fwd_data), 42);
    cyc();
    setWr(1'b0, 16'h0000, 16'd0);
    #1;
    check("coal_count", 32'(count), 2);
    check("coal_fwd_hit", 32'(fwd_hit), 1);
    check("coal_fwd_data", 32'(fwd_data), 99);
    check("coal_l2_addr", 32'(l2_addr), 16'h0001);
    check("coal_l2_data", 32'(l2_data), 99);
    cyc();
    check("coal_next_data", 32'(l2_data), 51);
    check("coal_next_count", 32'(count), 1);
    cyc();
    check("coal_drained", 32'(empty), 1);

    // back-to-back drain with ack held high
    setWr(1'b1, 16'h0004, 16'd10);
    cyc();
    setWr(1'b1, 16'h0005, 16'd11);
    cyc();
    check("b2b_1_data", 32'(l2_data), 10);
    check("b2b_1_count", 32'(count), 2);
    setWr(1'b1, 16'h0006, 16'd12);
    cyc();
    setWr(1'b0, 16'h0000, 16'd0);
    check("b2b_2_req", 32'(l2_req), 1);
    check("b2b_2_data", 32'(l2_data), 11);
    check("b2b_2_count", 32'(count), 2);
    cyc();
    check("b2b_3_req", 32'(l2_req), 1);
    check("b2b_3_data", 32'(l2_data), 12);
    check("b2b_3_count", 32'(count), 1);
    cyc();
    check("b2b_end_req", 32'(l2_req), 0);
    check("b2b_end_empty", 32'(empty), 1);
    l2_ack = 1'b0;

    // fill to capacity
    for (int i = 0; i < 4; i++) begin
      setWr(1'b1, 16'h0010 + 16'(i), 16'(i + 1));
      cyc();
    end
    setWr(1'b1, 16'h0008, 16'd62);
    chk_addr = 16'h0008;
    #1;
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(wr_ready), 0);
    cyc();
    check("full_hold_count", 32'(count), 4);
    check("full_no_fwd", 32'(fwd_hit), 0);
    setWr(1'b1, 16'h0012, 16'd5);
    #1;
    check("full_coal_ready", 32'(wr_ready), 1);
    cyc();
    setWr(1'b1, 16'h0008, 16'd62);
    l2_ack = 1'b1;
    #1;
    check("full_ack_ready", 32'(wr_ready), 0);
    cyc();
    setWr(1'b0, 16'h0000, 16'd0);
    l2_ack   = 1'b0;
    chk_addr = 16'h0012;
    #1;
    check("full_ack_count", 32'(count), 3);
    check("full_ack_addr", 32'(l2_addr), 16'h0011);
    check("full_ack_data", 32'(l2_data), 2);
    check("full_coal_fwd", 32'(fwd_data), 5);

    // reset with a request outstanding
    reset = 1'b1;
    #1;
    check("rst2_wr_ready", 32'(wr_ready), 0);
    cyc();
    reset    = 1'b0;
    chk_addr = 16'h0011;
    #1;
    check("rst2_req", 32'(l2_req), 0);
    check("rst2_count", 32'(count), 0);
    check("rst2_empty", 32'(empty), 1);
    check("rst2_fwd_hit", 32'(fwd_hit), 0);
    check("rst2_fwd_data", 32'(fwd_data), 0);
    cyc();
    cyc();
    check("rst2_no_retry", 32'(l2_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
